// File: rtl/div_unit.sv
// Multi-cycle signed divider (radix-2 restoring on magnitudes): LO = quotient, HI = remainder.
// One quotient bit per cycle; sign fix-up and result write happen in a final FIX cycle.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DivControl,
   input  logic [WIDTH-1:0] AFio,
   input  logic [WIDTH-1:0] BFio,
   output logic [WIDTH-1:0] DivLoFio,
   output logic [WIDTH-1:0] DivHiFio,
   output logic             fim,
   output logic             divZero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             sa_q, sa_d, sb_q, sb_d, dzp_q, dzp_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
   logic             fim_q, fim_d, dz_q, dz_d;

   logic [WIDTH+1:0] shift, trial;

   // Remainder is kept WIDTH+1 wide so the divisor magnitude 2^(WIDTH-1) never truncates.
   assign shift = {rem_q, quo_q[WIDTH-1]};
   assign trial = shift - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dzp_d   = dzp_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      fim_d   = fim_q;
      dz_d    = dz_q;
      if (DivControl) begin
         quo_d   = AFio[WIDTH-1] ? -AFio : AFio;
         dvs_d   = BFio[WIDTH-1] ? -{1'b1, BFio} : {1'b0, BFio};
         rem_d   = '0;
         count_d = '0;
         sa_d    = AFio[WIDTH-1];
         sb_d    = BFio[WIDTH-1];
         a_d     = AFio;
         dzp_d   = (BFio == '0);
         lo_d    = '0;
         hi_d    = '0;
         fim_d   = 1'b0;
         dz_d    = 1'b0;
         state_d = (BFio == '0) ? S_FIX : S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
               rem_d   = trial[WIDTH+1] ? shift[WIDTH:0] : trial[WIDTH:0];
               count_d = count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
               if (dzp_q) begin
                  lo_d = '1;
                  hi_d = a_q;
                  dz_d = 1'b1;
               end else begin
                  lo_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
                  hi_d = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
               end
               fim_d   = 1'b1;
               state_d = S_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dzp_q   <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         fim_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dzp_q   <= dzp_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         fim_q   <= fim_d;
         dz_q    <= dz_d;
      end
   end

   assign DivLoFio = lo_q;
   assign DivHiFio = hi_q;
   assign fim      = fim_q;
   assign divZero  = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: scoreboard of expected LO/HI/divZero/latency, popped when fim rises.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        DivControl;
   logic [31:0] AFio, BFio;
   logic [31:0] DivLoFio, DivHiFio;
   logic        fim, divZero;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .DivControl(DivControl),
      .AFio      (AFio),
      .BFio      (BFio),
      .DivLoFio  (DivLoFio),
      .DivHiFio  (DivHiFio),
      .fim       (fim),
      .divZero   (divZero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint la, lb, q, r;
      if (b == 32'd0) begin
         e.lo = 32'hFFFF_FFFF;
         e.hi = a;
         e.dz = 1'b1;
         e.lat = 1;
      end else begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
         q  = la / lb;
         r  = la % lb;
         e.lo = q[31:0];
         e.hi = r[31:0];
         e.dz = 1'b0;
         e.lat = 33;
      end
      return e;
   endfunction

   // Called at the negedge right after the final start edge.
   task automatic wait_result(input string tag);
      exp_t e;
      int   cyc;
      e = sb.pop_front();
      check({tag, ".fim_low"}, {31'd0, fim}, 32'd0);
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (fim) break;
      end
      check({tag, ".fim"}, {31'd0, fim}, 32'd1);
      check({tag, ".lat"}, cyc, e.lat);
      check({tag, ".lo"}, DivLoFio, e.lo);
      check({tag, ".hi"}, DivHiFio, e.hi);
      check({tag, ".dz"}, {31'd0, divZero}, {31'd0, e.dz});
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
      sb.push_back(model(a, b));
      @(negedge clk);
      AFio = a; BFio = b; DivControl = 1'b1;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      DivControl = 1'b0;
      AFio = $urandom; BFio = $urandom;
      wait_result(tag);
   endtask

   initial begin
      int fim_seen;
      exp_t dummy;
      reset = 1'b1; DivControl = 1'b0; AFio = '0; BFio = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.lo", DivLoFio, 32'd0);
      check("rst.hi", DivHiFio, 32'd0);
      check("rst.fim", {31'd0, fim}, 32'd0);
      check("rst.dz", {31'd0, divZero}, 32'd0);
      @(negedge clk); reset = 1'b0;

      run_div("p7d2", 32'd7, 32'd2, 1);
      run_div("n7d2", -32'sd7, 32'd2, 1);
      run_div("p7dn2", 32'd7, -32'sd2, 1);
      run_div("dz", 32'd100, 32'd0, 1);
      run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1);
      run_div("minby1", 32'h8000_0000, 32'd1, 1);
      run_div("small", 32'd3, 32'd7, 1);
      run_div("held", 32'd50, -32'sd7, 4);
      // explicit table values for the corner cases above
      check("tbl.ovf", model(32'h8000_0000, 32'hFFFF_FFFF).lo, 32'h8000_0000);

      // abort and restart mid-run: only the second operation yields a result
      sb.push_back(model(32'd20, 32'd3));
      @(negedge clk);
      AFio = 32'd20; BFio = 32'd3; DivControl = 1'b1;
      @(posedge clk);
      @(negedge clk); DivControl = 1'b0;
      repeat (9) @(posedge clk);
      dummy = sb.pop_back();
      run_div("restart", 32'd9, 32'd4, 1);

      // reset in the middle of an operation
      @(negedge clk);
      AFio = 32'd1234; BFio = 32'd5; DivControl = 1'b1;
      @(posedge clk);
      @(negedge clk); DivControl = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("midrst.lo", DivLoFio, 32'd0);
      check("midrst.hi", DivHiFio, 32'd0);
      check("midrst.fim", {31'd0, fim}, 32'd0);
      check("midrst.dz", {31'd0, divZero}, 32'd0);
      @(negedge clk); reset = 1'b0;
      fim_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (fim) fim_seen++;
      end
      check("midrst.nofim", fim_seen, 0);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         if (i % 3 == 0) b = b >> ($urandom_range(31, 16));
         if (b == 32'd0) b = 32'd3;
         run_div($sformatf("rnd%0d", i), a, b, 1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
